// File: rtl/fetch_stage_pkg.sv
// LC-3b shared types plus the fetch-stage state encoding and NOP constant.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package fetch_stage_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [3:0]  lc3b_opcode;

    // REQ: request up; HOLD: fetched word parked while decode stalls;
    // DRAIN: a stale request is still in flight after a redirect.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } lc3b_fetch_state;

    localparam lc3b_word lc3b_nop = 16'h0000;

    // Sequential fetch step; wraps modulo 2^16.
    function automatic lc3b_word pc_inc(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_latch.sv
// IF/ID pipeline register (valid, pc, ir) with combinational field decode.
// Latency: 1 cycle from load/flush to outputs.
// Backpressure: holds contents when neither load nor flush is asserted.
module fetch_stage_if_id_latch
    import fetch_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       flush_i,
    input  lc3b_word   pc_i,
    input  lc3b_word   ir_i,
    output logic       valid_o,
    output lc3b_word   pc_o,
    output lc3b_word   ir_o,
    output lc3b_opcode opcode_o,
    output lc3b_reg    dest_o,
    output lc3b_reg    sr1_o,
    output lc3b_reg    sr2_o,
    output logic       bit5_o
);

    logic     valid_q;
    lc3b_word pc_q;
    lc3b_word ir_q;

    // Register update: flush inserts a bubble and wins over load.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_q <= 1'b0;
            pc_q    <= 16'h0000;
            ir_q    <= lc3b_nop;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            ir_q    <= ir_i;
        end
    end

    assign valid_o  = valid_q;
    assign pc_o     = pc_q;
    assign ir_o     = ir_q;
    assign opcode_o = ir_q[15:12];
    assign dest_o   = ir_q[11:9];
    assign sr1_o    = ir_q[8:6];
    assign sr2_o    = ir_q[2:0];
    assign bit5_o   = ir_q[5];

endmodule

// File: rtl/fetch_stage.sv
// LC-3b IF stage: PC, imem request handshake, one-word hold buffer, IF/ID register.
// Latency: fetched word reaches IF/ID on the edge that sees imem_resp (or on release from HOLD).
// Backpressure: forward_load=0 parks a returned word in the hold buffer and drops imem_read.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       forward_load,
    input  logic       redirect,
    input  lc3b_word   redirect_pc,
    output logic       imem_read,
    output lc3b_word   imem_address,
    input  lc3b_word   imem_rdata,
    input  logic       imem_resp,
    output logic       if_id_valid,
    output lc3b_word   if_id_pc,
    output lc3b_word   if_id_ir,
    output lc3b_opcode if_id_opcode,
    output lc3b_reg    if_id_dest,
    output lc3b_reg    if_id_sr1,
    output lc3b_reg    if_id_sr2,
    output logic       if_id_bit5
);

    lc3b_fetch_state state_q, state_d;
    lc3b_word        pc_q, pc_d;
    lc3b_word        hold_q, hold_d;
    lc3b_word        drain_addr_q, drain_addr_d;
    logic            ld_ifid;
    logic            flush_ifid;
    lc3b_word        ld_ir;

    // A stale request keeps its original address even after pc moves to the target.
    assign imem_read    = !reset && (state_q == REQ || state_q == DRAIN);
    assign imem_address = (state_q == DRAIN) ? drain_addr_q : pc_q;

    // Next state: redirect first, then the per-state advance/stall rules.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        drain_addr_d = drain_addr_q;
        ld_ifid      = 1'b0;
        flush_ifid   = 1'b0;
        ld_ir        = imem_rdata;
        if (redirect) begin
            flush_ifid = 1'b1;
            pc_d       = redirect_pc & ~16'h0001;
            unique case (state_q)
                REQ: begin
                    if (!imem_resp) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                HOLD:    state_d = REQ;
                DRAIN:   state_d = imem_resp ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_resp) begin
                        if (forward_load) begin
                            ld_ifid = 1'b1;
                            pc_d    = pc_inc(pc_q);
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end else if (forward_load) begin
                        flush_ifid = 1'b1;
                    end
                end
                HOLD: begin
                    if (forward_load) begin
                        ld_ifid = 1'b1;
                        ld_ir   = hold_q;
                        pc_d    = pc_inc(pc_q);
                        state_d = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_resp) state_d = REQ;
                    if (forward_load) flush_ifid = 1'b1;
                end
                default: state_d = REQ;
            endcase
        end
    end

    // State, PC, hold buffer and drain address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            hold_q       <= lc3b_nop;
            drain_addr_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    fetch_stage_if_id_latch u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ld_ifid),
        .flush_i  (flush_ifid),
        .pc_i     (pc_inc(pc_q)),
        .ir_i     (ld_ir),
        .valid_o  (if_id_valid),
        .pc_o     (if_id_pc),
        .ir_o     (if_id_ir),
        .opcode_o (if_id_opcode),
        .dest_o   (if_id_dest),
        .sr1_o    (if_id_sr1),
        .sr2_o    (if_id_sr2),
        .bit5_o   (if_id_bit5)
    );

    // Memory never answers while no request is up.
    a_no_resp_in_hold: assert property (@(posedge clk) disable iff (reset)
        !(state_q == HOLD && imem_resp));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        forward_load;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        if_id_valid;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_ir;
    logic [3:0]  if_id_opcode;
    logic [2:0]  if_id_dest;
    logic [2:0]  if_id_sr1;
    logic [2:0]  if_id_sr2;
    logic        if_id_bit5;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .forward_load (forward_load),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_ir     (if_id_ir),
        .if_id_opcode (if_id_opcode),
        .if_id_dest   (if_id_dest),
        .if_id_sr1    (if_id_sr1),
        .if_id_sr2    (if_id_sr2),
        .if_id_bit5   (if_id_bit5)
    );

    typedef struct {
        logic        v;
        logic [15:0] pc;
        logic [15:0] ir;
        logic        rd;
        logic [15:0] addr;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model of what the fetch stage must present.
    logic [15:0] m_pc;       // address of next instruction to fetch
    bit          m_hasbuf;   // a fetched word waits for decode
    logic [15:0] m_buf;
    bit          m_stale;    // an abandoned request is still in flight
    logic [15:0] m_drain;    // its address
    logic        e_v;
    logic [15:0] e_pc;
    logic [15:0] e_ir;

    // Memory model.
    logic [15:0] mem [logic [15:0]];
    bit          pending = 0;
    int          cnt = 0;
    logic [15:0] paddr = 16'h0000;

    // Inputs applied during the previous cycle (what the DUT saw at the edge).
    bit          p_rst = 1'b1, p_redir = 1'b0, p_fl = 1'b0, p_resp = 1'b0;
    logic [15:0] p_rpc = 16'h0000, p_rdata = 16'h0000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] memword(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    task automatic deliver(input logic [15:0] w);
        e_v  = 1'b1;
        e_pc = m_pc + 16'd2;
        e_ir = w;
        m_pc = m_pc + 16'd2;
    endtask

    task automatic bubble();
        e_v  = 1'b0;
        e_pc = 16'h0000;
        e_ir = 16'h0000;
    endtask

    // Apply one clock edge's worth of rules to the model.
    task automatic model_step(input bit rst, input bit redir, input logic [15:0] rpc,
                              input bit fl, input bit resp, input logic [15:0] rd);
        bit nstale;
        if (rst) begin
            m_pc = 16'h0000; m_hasbuf = 0; m_stale = 0; m_drain = 16'h0000;
            bubble();
        end else if (redir) begin
            nstale = !resp && !m_hasbuf;
            if (nstale && !m_stale) m_drain = m_pc;
            m_stale  = nstale;
            m_hasbuf = 0;
            m_pc     = rpc & 16'hFFFE;
            bubble();
        end else if (m_stale) begin
            if (resp) m_stale = 0;
            if (fl) bubble();
        end else if (m_hasbuf) begin
            if (fl) begin deliver(m_buf); m_hasbuf = 0; end
        end else if (resp) begin
            if (fl) deliver(rd);
            else begin m_buf = rd; m_hasbuf = 1; end
        end else if (fl) begin
            bubble();
        end
    endtask

    // One cycle: advance model, drive new inputs, run memory, queue expectation.
    task automatic cycle(input bit rst, input bit redir, input logic [15:0] rpc,
                         input bit fl, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        model_step(p_rst, p_redir, p_rpc, p_fl, p_resp, p_rdata);
        reset = rst; redirect = redir; redirect_pc = rpc; forward_load = fl;
        #1;
        imem_resp = 1'b0;
        if (rst) begin
            pending = 0;
        end else if (pending) begin
            chk("req_held_read", {15'd0, imem_read}, 16'h0001);
            chk("req_held_addr", imem_address, paddr);
            cnt--;
            if (cnt == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = memword(paddr);
                pending    = 0;
            end
        end else if (imem_read) begin
            pending    = 1;
            paddr      = imem_address;
            cnt        = (lat > 0) ? lat : int'($urandom_range(1, 3));
            imem_rdata = 16'($urandom);
        end
        e.v    = e_v;
        e.pc   = e_pc;
        e.ir   = e_ir;
        e.rd   = !rst && !m_hasbuf;
        e.addr = m_stale ? m_drain : m_pc;
        sbq.push_back(e);
        p_rst = rst; p_redir = redir; p_rpc = rpc; p_fl = fl;
        p_resp = imem_resp; p_rdata = imem_rdata;
    endtask

    // Monitor: compares DUT outputs against queued expectations each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("if_id_valid",  {15'd0, if_id_valid},  {15'd0, e.v});
                chk("if_id_pc",     if_id_pc,              e.pc);
                chk("if_id_ir",     if_id_ir,              e.ir);
                chk("if_id_opcode", {12'd0, if_id_opcode}, {12'd0, e.ir[15:12]});
                chk("if_id_dest",   {13'd0, if_id_dest},   {13'd0, e.ir[11:9]});
                chk("if_id_sr1",    {13'd0, if_id_sr1},    {13'd0, e.ir[8:6]});
                chk("if_id_sr2",    {13'd0, if_id_sr2},    {13'd0, e.ir[2:0]});
                chk("if_id_bit5",   {15'd0, if_id_bit5},   {15'd0, e.ir[5]});
                chk("imem_read",    {15'd0, imem_read},    {15'd0, e.rd});
                if (e.rd) chk("imem_address", imem_address, e.addr);
            end
        end
    end

    initial begin
        reset = 1'b1; forward_load = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_resp = 1'b0; imem_rdata = 16'h0000;
        // reset, then back-to-back fetch with single-cycle memory
        repeat (3) cycle(1, 0, 16'h0000, 1, 1);
        repeat (8) cycle(0, 0, 16'h0000, 1, 1);
        // decode stall: word parks, then drains
        repeat (4) cycle(0, 0, 16'h0000, 0, 1);
        repeat (4) cycle(0, 0, 16'h0000, 1, 1);
        // redirect to odd target while a slow response is pending
        cycle(0, 0, 16'h0000, 1, 3);
        cycle(0, 1, 16'h3001, 1, 3);
        cycle(0, 0, 16'h0000, 1, 3);
        repeat (6) cycle(0, 0, 16'h0000, 1, 1);
        // redirect while stalled with a parked word
        repeat (3) cycle(0, 0, 16'h0000, 0, 1);
        cycle(0, 1, 16'h1234, 0, 1);
        repeat (4) cycle(0, 0, 16'h0000, 1, 1);
        // fetch from the top of memory wraps to 0000
        cycle(0, 1, 16'hFFFE, 1, 1);
        repeat (5) cycle(0, 0, 16'h0000, 1, 1);
        // reset while a request is outstanding
        cycle(0, 1, 16'h4000, 1, 2);
        cycle(0, 0, 16'h0000, 1, 2);
        repeat (2) cycle(1, 0, 16'h0000, 1, 2);
        repeat (5) cycle(0, 0, 16'h0000, 1, 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 11) == 0),
                  16'($urandom),
                  ($urandom_range(0, 9) < 7),
                  0);
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
